// File: rtl/hilo_div_sequencer.sv
// DIV/DIVU sequencer writing {HI,LO}; 35-cycle latency from start to whilo_we (2 for a zero divisor with HILO_DIV_ZERO_FAST_EN).
// Backpressure: stall holds the issue stage from the accept cycle until the DONE write; starts while busy are dropped.
// Optional macro: HILO_DIV_ZERO_FAST_EN short-circuits a zero divisor from PREP straight to DONE.
module hilo_div_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  input  logic                flush,
  output logic                busy,
  output logic                stall,
  output logic                whilo_we,
  output logic [2*DATA_W-1:0] whilo_data
);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_reg, b_reg, b_mag, quo, rem;
  logic                sgn_reg, qneg, rneg;
  logic [DATA_W:0]     rem_shift, rem_diff;
  logic                quo_bit, accept, b_zero;

  assign accept = (state == IDLE) && start && !flush;
  assign b_zero = (b_reg == '0);

  // 33-bit trial subtract: a clear borrow bit means the shifted remainder covers the divisor.
  assign rem_shift = {rem, quo[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, b_mag};
  assign quo_bit   = ~rem_diff[DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    stall     = ((state != IDLE) && (state != DONE)) || accept;
    whilo_we  = (state == DONE);
    case (state)
      IDLE: if (accept) state_nxt = PREP;
      PREP: begin
`ifdef HILO_DIV_ZERO_FAST_EN
        if (b_zero) state_nxt = DONE;
        else        state_nxt = RUN;
`else
        state_nxt = RUN;
`endif
      end
      RUN:  if (cnt == '1) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      b_mag      <= '0;
      quo        <= '0;
      rem        <= '0;
      sgn_reg    <= 1'b0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      whilo_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= dividend;
            b_reg   <= divisor;
            sgn_reg <= is_signed;
          end
        end
        PREP: begin
          b_mag <= (sgn_reg && b_reg[DATA_W-1]) ? -b_reg : b_reg;
          quo   <= (sgn_reg && a_reg[DATA_W-1]) ? -a_reg : a_reg;
          rem   <= '0;
          cnt   <= '0;
          qneg  <= sgn_reg && (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]);
          rneg  <= sgn_reg && a_reg[DATA_W-1];
`ifdef HILO_DIV_ZERO_FAST_EN
          if (b_zero && !flush) whilo_data <= {a_reg, {DATA_W{1'b1}}};
`endif
        end
        RUN: begin
          rem <= quo_bit ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], quo_bit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // Result lands here so a flush in FIX leaves the previous {HI,LO} intact.
          if (!flush) begin
            if (b_zero) whilo_data <= {a_reg, {DATA_W{1'b1}}};
            else        whilo_data <= {(rneg ? -rem : rem), (qneg ? -quo : quo)};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
